// File: rtl/spi_flash_read_ctrl.sv
// rtl/spi_flash_read_ctrl.sv - single-lane SPI flash 03h READ master with byte stream output
module spi_flash_read_ctrl #(
    parameter int SCK_HALF = 2,
    parameter int CSN_IDLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic        busy,
    output logic        sck,
    output logic        csn,
    output logic        mosi,
    input  logic        miso
);

    localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int GAP_W = (CSN_IDLE > 1) ? $clog2(CSN_IDLE) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCK_HALF - 1);
    localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(CSN_IDLE - 1);
    localparam logic [7:0] READ_CMD = 8'h03;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_DATA, S_TAIL, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             sck_q, csn_q, mosi_q;
    logic [30:0]      sh_q;          // bits 30..0 of {03h, addr}; bit 31 goes out at acceptance
    logic [4:0]       cnt_q;         // rises within SHIFT; low 3 bits are bit-in-byte in DATA
    logic [7:0]       byte_cnt_q;    // bytes remaining after the current one
    logic [7:0]       in_q;
    logic             in_full_q;     // in_q holds a completed byte not yet handed over
    logic [7:0]       rdata_q;
    logic             rdata_valid_q;
    logic [GAP_W-1:0] gap_q;

    logic accept, sck_active, div_tc, stall, rise, fall;
    logic byte_done, tail_done, gap_done, xfer;

    assign accept     = cmd_valid && (state_q == S_IDLE);
    assign sck_active = (state_q == S_SHIFT) || (state_q == S_DATA) || (state_q == S_TAIL);
    assign div_tc     = (div_q == DIV_TC);
    // The first rise of a byte would overwrite in_q while the previous byte is still parked there.
    assign stall      = (state_q == S_DATA) && !sck_q && (cnt_q[2:0] == 3'd0) && in_full_q;
    assign rise       = ((state_q == S_SHIFT) || (state_q == S_DATA)) && div_tc && !sck_q && !stall;
    assign fall       = sck_active && div_tc && sck_q;
    assign byte_done  = rise && (state_q == S_DATA) && (cnt_q[2:0] == 3'd7);
    assign tail_done  = (state_q == S_TAIL) && div_tc && !sck_q;
    assign gap_done   = (state_q == S_GAP) && (gap_q == GAP_TC);
    assign xfer       = in_full_q && (!rdata_valid_q || rdata_ready);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cmd_valid)                           state_d = S_SHIFT;
            S_SHIFT: if (rise && (cnt_q == 5'd31))            state_d = S_DATA;
            S_DATA:  if (byte_done && (byte_cnt_q == 8'd0))   state_d = S_TAIL;
            S_TAIL:  if (tail_done)                           state_d = S_GAP;
            S_GAP:   if (gap_done)                            state_d = S_IDLE;
            default:                                          state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the registered pin/stream drivers.
    always_comb begin
        cmd_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        sck         = sck_q;
        csn         = csn_q;
        mosi        = mosi_q;
        rdata       = rdata_q;
        rdata_valid = rdata_valid_q;
    end

    // SCK half-period divider; held at zero while stalled so the resumed rise is a full half-period later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    div_q <= '0;
        else if (!sck_active || stall || div_tc)    div_q <= '0;
        else                                        div_q <= div_q + DIV_W'(1);
    end

    // SPI pins: sck toggles at terminal count, mosi changes only on falls, csn framed by accept/tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= 1'b0;
            csn_q  <= 1'b1;
            mosi_q <= 1'b0;
        end else begin
            if (rise)      sck_q <= 1'b1;
            else if (fall) sck_q <= 1'b0;

            if (accept)         csn_q <= 1'b0;
            else if (tail_done) csn_q <= 1'b1;

            if (accept)    mosi_q <= READ_CMD[7];
            else if (fall) mosi_q <= (state_q == S_SHIFT) ? sh_q[30] : 1'b0;
        end
    end

    // Command/address out-shifter and bit/byte counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q       <= '0;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            gap_q      <= '0;
        end else begin
            if (accept)                             sh_q <= {READ_CMD[6:0], cmd_addr};
            else if (fall && (state_q == S_SHIFT))  sh_q <= {sh_q[29:0], 1'b0};

            if (accept)    cnt_q <= '0;
            else if (rise) cnt_q <= cnt_q + 5'd1;

            if (accept)                                  byte_cnt_q <= cmd_len;
            else if (byte_done && (byte_cnt_q != 8'd0))  byte_cnt_q <= byte_cnt_q - 8'd1;

            if (tail_done)              gap_q <= '0;
            else if (state_q == S_GAP)  gap_q <= gap_q + GAP_W'(1);
        end
    end

    // miso in-shifter and hand-off into the registered rdata stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q          <= '0;
            in_full_q     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            if (rise && (state_q == S_DATA)) in_q <= {in_q[6:0], miso};

            if (byte_done)  in_full_q <= 1'b1;
            else if (xfer)  in_full_q <= 1'b0;

            if (xfer) begin
                rdata_q       <= in_q;
                rdata_valid_q <= 1'b1;
            end else if (rdata_ready) begin
                rdata_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_flash_read_ctrl.md
# spi_flash_read_ctrl

SPI flash read master: accepts a read request (24-bit byte address, byte count), issues a single-lane 03h READ on the flash pins, and returns the read bytes on a valid/ready byte stream. Sits between on-chip bus logic (boot loader / cache-fill) and the external SPI flash. Synthesisable, SPI mode 0, MSB first, one clock domain.

## Interface
Parameters:
- SCK_HALF: 2; clk cycles per SCK half-period, ≥1.
- CSN_IDLE: 4; minimum clk cycles csn stays high between transactions, ≥1.

Ports:
- clk  in  1  system clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  read request valid.
- cmd_ready  out  1  controller can accept a request; high only in IDLE.
- cmd_addr  in  24  first byte address.
- cmd_len  in  8  byte count minus 1 (0 → 1 byte, 255 → 256 bytes).
- rdata  out  8  returned byte.
- rdata_valid  out  1  rdata holds an unconsumed byte.
- rdata_ready  in  1  consumer accepts rdata.
- busy  out  1  high from request acceptance until return to IDLE.
- sck  out  1  SPI clock, idles low.
- csn  out  1  chip select, active low.
- mosi  out  1  to flash IO0.
- miso  in  1  from flash IO1.

## Operation
- States: IDLE, SHIFT (cmd+addr, 32 bits out), DATA (8·(cmd_len+1) bits in), TAIL, GAP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch {8'h03, cmd_addr} into a 32-bit out-shifter, cmd_len into a byte counter; csn←0, mosi←bit 31 (0); go to SHIFT.
- SCK generation: divider counts SCK_HALF cycles per half-period; sck toggles at terminal count. mosi changes only on the cycle sck falls (and at acceptance). miso sampled into an 8-bit in-shifter on the cycle sck rises.
- SHIFT: after the 32nd rising edge, enter DATA; mosi held at 0 during DATA.
- DATA: each 8 rises completes a byte; completed byte moves from in-shifter to the rdata holding register whenever that register is empty or being consumed that cycle (rdata_valid&rdata_ready).
- Backpressure: the rising edge carrying bit 7 of byte b (b≥1) is withheld, sck held low and divider frozen, while byte b−1 is still in the in-shifter. Resumes one full half-period after the transfer. sck never stops high.
- After the final byte's 8th rise: TAIL lets sck fall after SCK_HALF; csn←1 SCK_HALF cycles after that fall; GAP holds csn high CSN_IDLE cycles, then IDLE. Final byte may still be in rdata on IDLE entry; a new request may be accepted meanwhile and streams behind it.
- Address is not range-checked; flash wraps internally.
- busy=1 in every state except IDLE.

## Timing
- Reset values: csn=1, sck=0, mosi=0, rdata=0, rdata_valid=0, busy=0, cmd_ready=1; state IDLE. Async assert mid-transaction aborts immediately (csn high same instant); no partial byte emitted.
- Acceptance at edge T: csn low, mosi=0 from T. Rise k (k=0..) at T+SCK_HALF·(2k+1), absent stalls.
- Byte b captured at rise 32+8b+7; rdata_valid high the following cycle if holding register free.
- Unstalled transaction: csn low from T to T+SCK_HALF·(2·(32+8(cmd_len+1))+1), cmd_ready returns CSN_IDLE cycles later.
- rdata and rdata_valid are registered; rdata stable while rdata_valid&!rdata_ready.
- cmd_valid while busy is ignored (no latching).

## Test plan
- Single byte: mem[0x000010]=0xA5, addr=0x10, len=0, rdata_ready=1, SCK_HALF=2 -> exactly 40 sck rises, mosi pattern 0x03,0x000010; one rdata=0xA5; csn high at T+162.
- Burst of 4 from 0x0100 preloaded 0x11,0x22,0x33,0x44 -> bytes in order, 64 rises, no sck gaps.
- Backpressure: len=3, rdata_ready low for 100 cycles after first byte -> byte 1 captured, rise for byte 2 withheld with sck low; after release, all 4 bytes correct, no duplication/loss.
- Back-to-back: second request presented while first's last byte unconsumed -> csn high ≥CSN_IDLE cycles between, both streams correct and ordered.
- Reset mid-DATA after 2 of 8 bytes -> csn=1, sck=0, rdata_valid=0 immediately; following request at 0x0200 returns correct data.
- SCK_HALF=1, len=255 at 0xFFFF00 -> 256 bytes at full rate, each matching memory.
